// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and the
// default widths / timeout length used by apb_master_8bits and its
// wait-state counter.
package apb_master_pkg;

  localparam int APB_ADDR_WIDTH_DEF     = 8;
  localparam int APB_DATA_WIDTH_DEF     = 8;
  localparam int APB_TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter for the APB ACCESS phase. Cleared while the requester
// is in SETUP, counts each ACCESS cycle, and flags expiry during the
// TIMEOUT_CYCLES-th ACCESS cycle so the FSM can abort on that edge.
// Only instantiated when APB_TIMEOUT_EN is defined.
import apb_master_pkg::*;

module apb_wait_counter #(
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES_DEF
) (
  input  logic PCLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  // Count completed ACCESS cycles; the count holds once expiry is reached.
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc && !expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expired = inc && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_8bits.sv
// Single-outstanding APB requester. A command is taken over a valid/ready
// handshake, run as one SETUP + ACCESS transfer, and the result is held on
// the rsp_* port until consumed. All outputs come straight from flops.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that
// lasts TIMEOUT_CYCLES cycles without PREADY.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | cmd_ready=1, waiting for cmd_valid
// ST_SETUP  | PSEL=1, PENABLE=0, command on PADDR/PWRITE/PWDATA
// ST_ACCESS | PSEL=1, PENABLE=1, waiting for PREADY (or timeout)
// ST_RESP   | rsp_valid=1, result held until rsp_ready
import apb_master_pkg::*;

module apb_master_8bits #(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES_DEF
) (
  input  logic                  PCLK,
  input  logic                  RST,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  apb_state_t state;

`ifdef APB_TIMEOUT_EN
  logic timeout_hit;

  apb_wait_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .PCLK    (PCLK),
    .RST     (RST),
    .clr     (state == ST_SETUP),
    .inc     (state == ST_ACCESS),
    .expired (timeout_hit)
  );
`else
  assign rsp_timeout = 1'b0;
`endif

  // Transfer sequencer with registered APB and handshake outputs.
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            PADDR     <= cmd_addr;
            PWRITE    <= cmd_write;
            PWDATA    <= cmd_wdata;
            PSEL      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // PREADY is checked first so a completion on the expiry cycle wins.
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
`ifdef APB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
`endif
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_8bits.sv
// Self-checking bench for apb_master_8bits: directed corner cases followed
// by randomized transfers against a memory-backed APB completer, with a
// scoreboard monitor on the response port.
module tb_apb_master_8bits;

  localparam int TMO = 16;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic       to;
  } rsp_t;

  logic       PCLK = 1'b0;
  logic       RST;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err, rsp_timeout;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY, PSLVERR;
  logic [7:0] PRDATA;

  int n_vec = 0;
  int n_err = 0;

  rsp_t       exp_q[$];
  logic [7:0] ref_mem   [256];
  logic [7:0] slave_mem [256];

  apb_master_8bits dut (
    .PCLK        (PCLK),
    .RST         (RST),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .PRDATA      (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response scoreboard: pops on every handshake and checks hold stability.
  initial begin
    rsp_t       e;
    bit         held = 0;
    logic [7:0] h_rdata;
    logic       h_err, h_to;
    forever begin
      @(negedge PCLK);
      if (RST !== 1'b0) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_rdata", 32'(rsp_rdata), 32'(h_rdata));
          chk("hold_err", 32'(rsp_err), 32'(h_err));
          chk("hold_timeout", 32'(rsp_timeout), 32'(h_to));
        end
        if (rsp_valid && rsp_ready) begin
          held = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: got rdata=%0h err=%0b expected no response", rsp_rdata, rsp_err);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          end
        end else if (rsp_valid) begin
          held    = 1;
          h_rdata = rsp_rdata;
          h_err   = rsp_err;
          h_to    = rsp_timeout;
        end else begin
          held = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Waits (bounded) for the command handshake; returns at the SETUP cycle.
  task automatic accept(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (cmd_ready) ok = 1;
      tick();
      if (ok) break;
    end
    chk("accept", 32'(ok), 32'd1);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  // One complete transfer: waits = PREADY-low ACCESS cycles, hold = RESP
  // cycles with rsp_ready low (junk commands offered meanwhile).
  task automatic apb_xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                          input int waits, input bit err, input int hold);
    rsp_t e;
    bit   to_exp, ok, last;
    int   n_acc;
    to_exp = 0;
`ifdef APB_TIMEOUT_EN
    if (waits >= TMO) to_exp = 1;
`endif
    n_acc = to_exp ? TMO : waits + 1;
    if (to_exp) begin
      e.rdata = 8'h00; e.err = 1'b1; e.to = 1'b1;
    end else begin
      e.rdata = w ? 8'h00 : ref_mem[a];
      e.err   = err;
      e.to    = 1'b0;
      if (w && !err) ref_mem[a] = d;
    end
    exp_q.push_back(e);

    rsp_ready = (hold == 0);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    PREADY = 1'($urandom); PRDATA = 8'($urandom); PSLVERR = 1'($urandom);
    accept(ok);
    if (!ok) return;

    @(negedge PCLK);
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_paddr", 32'(PADDR), 32'(a));
    chk("setup_pwrite", 32'(PWRITE), 32'(w));
    chk("setup_pwdata", 32'(PWDATA), 32'(d));
    chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();

    for (int k = 0; k < n_acc; k++) begin
      last    = !to_exp && (k == waits);
      PREADY  = last;
      PRDATA  = (last && !w) ? slave_mem[PADDR] : 8'($urandom);
      PSLVERR = last ? err : 1'($urandom);
      @(negedge PCLK);
      chk("access_psel", 32'(PSEL), 32'd1);
      chk("access_penable", 32'(PENABLE), 32'd1);
      chk("access_paddr", 32'(PADDR), 32'(a));
      chk("access_pwrite", 32'(PWRITE), 32'(w));
      chk("access_pwdata", 32'(PWDATA), 32'(d));
      if (last && PWRITE && !err) slave_mem[PADDR] = PWDATA;
      tick();
    end
    PREADY = 1'b0;

    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom);
      cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
      @(negedge PCLK);
      chk("resp_valid_hold", 32'(rsp_valid), 32'd1);
      chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("resp_psel", 32'(PSEL), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_psel", 32'(PSEL), 32'd0);
    chk("resp_penable", 32'(PENABLE), 32'd0);
    tick();
    @(negedge PCLK);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_psel", 32'(PSEL), 32'd0);
    tick();
  endtask

  // Reset pulse in the middle of an ACCESS wait: the transfer must vanish.
  task automatic rst_in_access();
    bit ok;
    rsp_ready = 1'b1;
    PREADY    = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h03; cmd_wdata = 8'h77;
    accept(ok);
    tick();
    tick();
    @(negedge PCLK);
    chk("rst_pre_psel", 32'(PSEL), 32'd1);
    chk("rst_pre_penable", 32'(PENABLE), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rst_async_psel", 32'(PSEL), 32'd0);
    chk("rst_async_penable", 32'(PENABLE), 32'd0);
    chk("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge PCLK);
    @(negedge PCLK);
    #1 RST = 1'b0;
    tick();
    @(negedge PCLK);
    chk("rst_post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_post_psel", 32'(PSEL), 32'd0);
    chk("rst_post_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'h00;
      slave_mem[i] = 8'h00;
    end
    RST = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    #1 RST = 1'b0;
    tick();
    @(negedge PCLK);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_psel", 32'(PSEL), 32'd0);
    chk("reset_penable", 32'(PENABLE), 32'd0);
    chk("reset_pwrite", 32'(PWRITE), 32'd0);
    chk("reset_paddr", 32'(PADDR), 32'd0);
    chk("reset_pwdata", 32'(PWDATA), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    tick();

    // completer content for the directed read
    slave_mem[1] = 8'h3C;
    ref_mem[1]   = 8'h3C;

    apb_xfer(1'b1, 8'h00, 8'hA5, 0, 1'b0, 0);    // write, no wait states
    apb_xfer(1'b0, 8'h01, 8'h00, 2, 1'b0, 0);    // read, two wait states
    apb_xfer(1'b1, 8'h05, 8'h5A, 0, 1'b1, 0);    // write with PSLVERR
    apb_xfer(1'b0, 8'h00, 8'h00, 1, 1'b0, 5);    // read back, response held 5 cycles
    apb_xfer(1'b0, 8'h05, 8'h00, 0, 1'b0, 0);    // errored write left memory alone
    apb_xfer(1'b0, 8'h01, 8'h00, 100, 1'b0, 0);  // PREADY held low (timeout or long wait)
    apb_xfer(1'b1, 8'h02, 8'hC3, TMO - 1, 1'b0, 0); // PREADY on the last allowed cycle
    apb_xfer(1'b0, 8'h02, 8'h00, TMO - 1, 1'b0, 0);
    rst_in_access();
    apb_xfer(1'b0, 8'h03, 8'h00, 0, 1'b0, 0);    // aborted write must not have landed
    apb_xfer(1'b1, 8'h03, 8'h99, 1, 1'b0, 1);

    for (int t = 0; t < 150; t++) begin
      apb_xfer(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom),
               int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0),
               int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
